// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round-key store.
// Build option: AES_KSTORE_ZEROIZE_EN clears the key store on reset and on load_start.
package aes_pkg;

   localparam int KEY_W    = 128;
   localparam int MAX_KEYS = 15;
   localparam int IDX_W    = 4;

   typedef enum logic [1:0] {
      KL_128 = 2'd0,
      KL_192 = 2'd1,
      KL_256 = 2'd2,
      KL_BAD = 2'd3
   } keylen_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_READY,
      S_STREAM
   } kstore_state_e;

   // A return value of 0 marks an illegal key length
   function automatic logic [IDX_W-1:0] nkeys_f(keylen_e kl);
      logic [IDX_W-1:0] n;
      n = '0;
      case (kl)
         KL_128:  n = IDX_W'(11);
         KL_192:  n = IDX_W'(13);
         KL_256:  n = IDX_W'(15);
         default: n = '0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/aes_rk_ram.sv
// Round-key store: one write port, one registered read port.
// Build option: AES_KSTORE_ZEROIZE_EN adds a zeroize input that clears every entry.
module aes_rk_ram
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
`ifdef AES_KSTORE_ZEROIZE_EN
   input  logic             zeroize,
`endif
   input  logic             we,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [KEY_W-1:0] wr_data,
   input  logic             re,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [KEY_W-1:0] rd_data
);

   logic [KEY_W-1:0] mem [MAX_KEYS];

   // A write on the zeroize edge lands after the clear and survives
   always_ff @(posedge clk) begin
`ifdef AES_KSTORE_ZEROIZE_EN
      if (zeroize) begin
         for (int i = 0; i < MAX_KEYS; i++) begin
            mem[i] <= '0;
         end
      end
`endif
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (re) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/aes_round_key_store.sv
// Captures an expanded AES key schedule and replays it forward or reverse.
// Build option: AES_KSTORE_ZEROIZE_EN zeroizes the store and masks out_key when idle.
module aes_round_key_store
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic [1:0]       keylen,
   input  logic             kx_valid,
   input  logic [IDX_W-1:0] kx_round,
   input  logic [KEY_W-1:0] kx_key,
   output logic             keys_valid,
   output logic             err,
   input  logic             stream_start,
   input  logic             dec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [KEY_W-1:0] out_key,
   output logic [IDX_W-1:0] out_round,
   output logic             out_last
);

   kstore_state_e    state;
   logic [IDX_W-1:0] nk_q;
   logic [IDX_W-1:0] wr_cnt;
   logic [IDX_W-1:0] rd_ptr;
   logic             dec_q;

   logic [IDX_W-1:0] nk_in;
   logic             legal_in;
   logic             loading;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] nk_cur;
   logic             wr_ok;
   logic             wr_bad;
   logic             wr_done;
   logic             start_ok;
   logic             hshake;
   logic [IDX_W-1:0] start_ptr;
   logic [IDX_W-1:0] nxt_ptr;
   logic [IDX_W-1:0] end_idx;
   logic             re;
   logic [IDX_W-1:0] rd_addr;
   logic [KEY_W-1:0] rd_data;

   assign nk_in    = nkeys_f(keylen_e'(keylen));
   assign legal_in = (nk_in != '0);

   // load_start restarts capture at index 0 in the same cycle
   assign loading = load_start ? legal_in : (state == S_LOAD);
   assign wr_idx  = load_start ? '0 : wr_cnt;
   assign nk_cur  = load_start ? nk_in : nk_q;
   assign wr_ok   = loading && kx_valid && (kx_round == wr_idx);
   assign wr_bad  = loading && kx_valid && (kx_round != wr_idx);
   assign wr_done = wr_ok && (wr_idx == nk_cur - IDX_W'(1));

   assign start_ok  = !load_start && stream_start && (state == S_READY);
   assign hshake    = (state == S_STREAM) && out_valid && out_ready;
   assign start_ptr = dec ? nk_q - IDX_W'(1) : '0;
   assign nxt_ptr   = dec_q ? rd_ptr - IDX_W'(1) : rd_ptr + IDX_W'(1);
   assign end_idx   = dec_q ? '0 : nk_q - IDX_W'(1);

   // Prefetch the next key on a handshake so beats sustain one per cycle
   assign re      = start_ok || (hshake && !out_last);
   assign rd_addr = start_ok ? start_ptr : nxt_ptr;

   aes_rk_ram u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef AES_KSTORE_ZEROIZE_EN
      .zeroize (!rst_n || load_start),
`endif
      .we      (wr_ok),
      .wr_addr (wr_idx),
      .wr_data (kx_key),
      .re      (re),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         nk_q       <= '0;
         wr_cnt     <= '0;
         rd_ptr     <= '0;
         dec_q      <= 1'b0;
         keys_valid <= 1'b0;
         err        <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else if (load_start) begin
         keys_valid <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         nk_q       <= nk_in;
         wr_cnt     <= wr_ok ? IDX_W'(1) : '0;
         err        <= !legal_in || wr_bad;
         state      <= (!legal_in || wr_bad) ? S_IDLE : S_LOAD;
      end else begin
         unique case (state)
            S_LOAD: begin
               if (wr_bad) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end else if (wr_ok) begin
                  wr_cnt <= wr_cnt + IDX_W'(1);
                  if (wr_done) begin
                     keys_valid <= 1'b1;
                     state      <= S_READY;
                  end
               end
            end
            S_READY: begin
               if (start_ok) begin
                  state     <= S_STREAM;
                  dec_q     <= dec;
                  rd_ptr    <= start_ptr;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
               end
            end
            S_STREAM: begin
               if (hshake) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= S_READY;
                  end else begin
                     rd_ptr   <= nxt_ptr;
                     out_last <= (nxt_ptr == end_idx);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_round = rd_ptr;

`ifdef AES_KSTORE_ZEROIZE_EN
   assign out_key = out_valid ? rd_data : '0;
`else
   assign out_key = rd_data;
`endif

endmodule
